// File: rtl/spi_master_ctrl_pkg.sv
// Shared types and constants for the SPI mode-0 master controller.
// Command byte layout is {addr[6:0], rw}, built by mkCmd.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_e;

  localparam logic RW_WRITE     = 1'b0;
  localparam logic RW_READ      = 1'b1;
  localparam int   HALF_DIV_DEF = 20;
  localparam int   CMD_W        = 8;
  localparam int   DATA_W       = 8;

  function automatic logic [CMD_W-1:0] mkCmd(input logic [6:0] addr, input logic rw);
    return {addr, rw};
  endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Controller-side request/response signals plus the SPI pins of the master.
// The master modport is the controller's view; slave is the bench/system view.
interface spi_master_ctrl_if;

  logic                      cs_n_in;
  logic                      wr_rd;
  logic [6:0]                spi_addr_master;
  logic [spi_pkg::DATA_W-1:0] spi_data_master;
  logic                      miso;
  logic                      cs_n;
  logic                      sclk;
  logic                      mosi;
  logic [spi_pkg::DATA_W-1:0] data_out;
  logic                      data_out_vld;

  modport master (
    input  cs_n_in, wr_rd, spi_addr_master, spi_data_master, miso,
    output cs_n, sclk, mosi, data_out, data_out_vld
  );

  modport slave (
    output cs_n_in, wr_rd, spi_addr_master, spi_data_master, miso,
    input  cs_n, sclk, mosi, data_out, data_out_vld
  );

endinterface

// File: rtl/spi_master_ctrl_sclk_gen.sv
// SCLK generator: low for HALF_DIV clocks, then high for HALF_DIV clocks, per bit.
// Ticks are combinational and flag the edge on which sclk will toggle.
module spi_sclk_gen #(
  parameter int HALF_DIV = spi_pkg::HALF_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_tick_o,
  output logic fall_tick_o,
  output logic bit_end_o
);

  localparam int CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             halfDone;

  assign halfDone    = en_i && (cnt_q == CNT_MAX);
  assign rise_tick_o = halfDone && !sclk_q;
  assign fall_tick_o = halfDone && sclk_q;
  assign bit_end_o   = fall_tick_o;
  assign sclk_o      = sclk_q;

  // Dropping en_i parks sclk low and restarts the half-period on the next frame.
  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (halfDone) begin
      cnt_d  = '0;
      sclk_d = !sclk_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: command byte {addr, rw} followed by data bytes for as long
// as cs_n_in stays low; read bytes come back on data_out with a one-cycle valid.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int HALF_DIV = HALF_DIV_DEF
) (
  input logic              clk,
  input logic              rst,
  spi_master_ctrl_if.master spi
);

  state_e              state_q, state_d;
  logic                rw_q, rw_d;
  logic [CMD_W-1:0]    tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   dataOut_q, dataOut_d;
  logic [2:0]          bitCnt_q, bitCnt_d;
  logic [15:0]         byteCnt_q, byteCnt_d;
  logic                csN_q, csN_d;
  logic                mosi_q, mosi_d;
  logic                vld_q, vld_d;

  logic                sclkEn;
  logic                sclk;
  logic                riseTick;
  logic                fallTick;
  logic                bitEnd;
  logic                byteEnd;
  logic [CMD_W-1:0]    cmd;
  logic [DATA_W-1:0]   nextTx;

  // Gating with cs_n_in lets sclk drop on the very edge that aborts the frame.
  assign sclkEn  = (state_q != IDLE) && !spi.cs_n_in;
  assign byteEnd = bitEnd && (bitCnt_q == 3'd7);
  assign cmd     = mkCmd(spi.spi_addr_master, spi.wr_rd);
  assign nextTx  = (rw_q == RW_READ) ? '0 : spi.spi_data_master;

  spi_sclk_gen #(
    .HALF_DIV(HALF_DIV)
  ) u_sclk_gen (
    .clk        (clk),
    .rst        (rst),
    .en_i       (sclkEn),
    .sclk_o     (sclk),
    .rise_tick_o(riseTick),
    .fall_tick_o(fallTick),
    .bit_end_o  (bitEnd)
  );

  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    dataOut_d = dataOut_q;
    bitCnt_d  = bitCnt_q;
    byteCnt_d = byteCnt_q;
    csN_d     = csN_q;
    mosi_d    = mosi_q;
    vld_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!spi.cs_n_in) begin
          state_d   = CMD;
          rw_d      = spi.wr_rd;
          tx_d      = cmd;
          mosi_d    = cmd[CMD_W-1];
          csN_d     = 1'b0;
          bitCnt_d  = '0;
          byteCnt_d = '0;
        end
      end
      default: begin
        if (spi.cs_n_in) begin
          state_d   = IDLE;
          csN_d     = 1'b1;
          mosi_d    = 1'b0;
          bitCnt_d  = '0;
          byteCnt_d = '0;
        end else begin
          if (riseTick) begin
            rx_d = {rx_q[DATA_W-2:0], spi.miso};
          end
          if (bitEnd) begin
            bitCnt_d = bitCnt_q + 3'd1;
          end
          // The byte boundary is also where the next byte is fetched and mosi set.
          if (byteEnd) begin
            state_d   = DATA;
            byteCnt_d = byteCnt_q + 16'd1;
            tx_d      = nextTx;
            mosi_d    = nextTx[DATA_W-1];
            if (state_q == DATA && rw_q == RW_READ) begin
              dataOut_d = rx_q;
              vld_d     = 1'b1;
            end
          end else if (fallTick) begin
            tx_d   = {tx_q[CMD_W-2:0], 1'b0};
            mosi_d = tx_q[CMD_W-2];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rw_q      <= RW_WRITE;
      tx_q      <= '0;
      rx_q      <= '0;
      dataOut_q <= '0;
      bitCnt_q  <= '0;
      byteCnt_q <= '0;
      csN_q     <= 1'b1;
      mosi_q    <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rw_q      <= rw_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      dataOut_q <= dataOut_d;
      bitCnt_q  <= bitCnt_d;
      byteCnt_q <= byteCnt_d;
      csN_q     <= csN_d;
      mosi_q    <= mosi_d;
      vld_q     <= vld_d;
    end
  end

  assign spi.cs_n         = csN_q;
  assign spi.sclk         = sclk;
  assign spi.mosi         = mosi_q;
  assign spi.data_out     = dataOut_q;
  assign spi.data_out_vld = vld_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a mode-0 slave model and a scoreboard
// of expected mosi bytes and read-back bytes.
module tb_spi_master_ctrl;
  import spi_pkg::*;

  localparam int HD       = 20;
  localparam int BIT_CLK  = 2 * HD;
  localparam int BYTE_CLK = 8 * BIT_CLK;

  logic clk = 1'b0;
  logic rst;

  always #10 clk = ~clk;

  spi_master_ctrl_if spiIf ();

  spi_master_ctrl #(
    .HALF_DIV(HD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .spi(spiIf)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] expMosi[$];
  logic [7:0] expVld[$];
  logic [7:0] wrData[$];
  logic [7:0] slaveBytes[$];
  logic [7:0] obsMosi[$];
  logic [7:0] obsVld[$];
  int         obsGap[$];
  int         mosiRd = 0;
  int         vldRd  = 0;

  // Slave model and mosi capture, driven by the SPI pins only.
  logic [7:0] sShift     = 8'h00;
  logic [7:0] mShift     = 8'h00;
  logic       prevCs     = 1'b1;
  logic       prevSclk   = 1'b0;
  int         sBit       = 0;
  int         sIdx       = 0;
  int         mBit       = 0;
  int         sclkPulses = 0;

  assign spiIf.miso = sShift[7];

  always @(spiIf.cs_n or spiIf.sclk) begin
    if (prevCs !== 1'b0 && spiIf.cs_n === 1'b0) begin
      mBit       = 0;
      sBit       = 0;
      sIdx       = 0;
      sShift     = 8'h00;
      sclkPulses = 0;
    end else if (spiIf.cs_n === 1'b0) begin
      if (prevSclk === 1'b0 && spiIf.sclk === 1'b1) begin
        sclkPulses++;
        mShift = {mShift[6:0], spiIf.mosi};
        mBit++;
        if (mBit == 8) begin
          mBit = 0;
          obsMosi.push_back(mShift);
        end
      end else if (prevSclk === 1'b1 && spiIf.sclk === 1'b0) begin
        sBit++;
        if (sBit % 8 == 0) begin
          sShift = (sIdx < slaveBytes.size()) ? slaveBytes[sIdx] : 8'h00;
          sIdx++;
        end else begin
          sShift = {sShift[6:0], 1'b0};
        end
      end
    end
    prevCs   = spiIf.cs_n;
    prevSclk = spiIf.sclk;
  end

  // Read-back monitor: records each valid byte and its distance in clocks from
  // the previous valid (or from cs_n falling for the first byte of a frame).
  int   cyc       = 0;
  int   lastEvt   = 0;
  logic prevCsClk = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (prevCsClk === 1'b1 && spiIf.cs_n === 1'b0) lastEvt = cyc;
    if (spiIf.data_out_vld === 1'b1) begin
      obsVld.push_back(spiIf.data_out);
      obsGap.push_back(cyc - lastEvt);
      lastEvt = cyc;
    end
    prevCsClk = spiIf.cs_n;
  end

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drains the scoreboard for the frame just run and checks the sclk pulse count.
  task automatic checkOutput(input string tag, input int expPulses);
    int nExp;
    int nObs;
    nExp = expMosi.size();
    nObs = obsMosi.size() - mosiRd;
    checkValue({tag, "_mosi_count"}, nObs, nExp);
    for (int i = 0; i < nExp; i++) begin
      if (i < nObs) checkValue({tag, "_mosi_byte"}, obsMosi[mosiRd + i], expMosi[i]);
    end
    mosiRd = obsMosi.size();
    expMosi.delete();

    nExp = expVld.size();
    nObs = obsVld.size() - vldRd;
    checkValue({tag, "_vld_count"}, nObs, nExp);
    for (int i = 0; i < nExp; i++) begin
      if (i < nObs) begin
        checkValue({tag, "_data_out"}, obsVld[vldRd + i], expVld[i]);
        checkValue({tag, "_vld_spacing"}, obsGap[vldRd + i], (i == 0) ? 2 * BYTE_CLK : BYTE_CLK);
      end
    end
    vldRd = obsVld.size();
    expVld.delete();

    checkValue({tag, "_sclk_pulses"}, sclkPulses, expPulses);
  endtask

  // endMode 0: frame of nBytes data bytes ends normally; 1: cs_n_in abort after
  // holdEdges clocks; 2: rst asserted after holdEdges clocks.
  task automatic applyStimulus(input string tag, input logic rw, input logic [6:0] addr,
                               input int nBytes, input int endMode, input int holdEdges);
    int total;
    int nComplete;
    int expPulses;
    int k;
    int mid;
    total     = (endMode == 0) ? BYTE_CLK * (nBytes + 1) + 1 : holdEdges;
    nComplete = (total - 1) / BYTE_CLK;
    expPulses = (total >= HD + 1) ? (total - HD - 1) / BIT_CLK + 1 : 0;
    mid       = BYTE_CLK / 2 + 1;

    if (nComplete >= 1) expMosi.push_back({addr, rw});
    for (int j = 0; j < nComplete - 1 && j < nBytes; j++) begin
      if (rw == RW_READ) begin
        expMosi.push_back(8'h00);
        expVld.push_back(slaveBytes[j]);
      end else begin
        expMosi.push_back(wrData[j]);
      end
    end

    @(negedge clk);
    spiIf.cs_n_in         = 1'b0;
    spiIf.wr_rd           = rw;
    spiIf.spi_addr_master = addr;
    spiIf.spi_data_master = (wrData.size() > 0) ? wrData[0] : 8'h00;

    for (int e = 1; e <= total; e++) begin
      @(posedge clk);
      if (e >= mid && (e - mid) % BYTE_CLK == 0 && e < total) begin
        k = (e - mid) / BYTE_CLK;
        @(negedge clk);
        spiIf.wr_rd           = ~rw;
        spiIf.spi_addr_master = ~addr;
        spiIf.spi_data_master = (k < wrData.size()) ? wrData[k] : 8'h5A;
      end
    end

    @(negedge clk);
    if (endMode == 0) begin
      spiIf.cs_n_in = 1'b1;
      repeat (2) @(negedge clk);
      checkValue({tag, "_cs_n_end"}, spiIf.cs_n, 1'b1);
    end else if (endMode == 1) begin
      checkValue({tag, "_sclk_before_abort"}, spiIf.sclk, 1'b1);
      spiIf.cs_n_in = 1'b1;
      @(negedge clk);
      checkValue({tag, "_abort_cs_n"}, spiIf.cs_n, 1'b1);
      checkValue({tag, "_abort_sclk"}, spiIf.sclk, 1'b0);
      checkValue({tag, "_abort_mosi"}, spiIf.mosi, 1'b0);
      repeat (2) @(negedge clk);
    end else begin
      rst = 1'b1;
      #1;
      checkValue({tag, "_rst_cs_n"}, spiIf.cs_n, 1'b1);
      checkValue({tag, "_rst_sclk"}, spiIf.sclk, 1'b0);
      checkValue({tag, "_rst_mosi"}, spiIf.mosi, 1'b0);
      checkValue({tag, "_rst_data_out"}, spiIf.data_out, 8'h00);
      checkValue({tag, "_rst_vld"}, spiIf.data_out_vld, 1'b0);
      spiIf.cs_n_in = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
    end

    checkOutput(tag, expPulses);
  endtask

  logic idleBusy;

  initial begin
    rst                   = 1'b1;
    spiIf.cs_n_in         = 1'b1;
    spiIf.wr_rd           = 1'b0;
    spiIf.spi_addr_master = 7'h00;
    spiIf.spi_data_master = 8'h00;
    repeat (3) @(negedge clk);
    checkValue("reset_cs_n", spiIf.cs_n, 1'b1);
    checkValue("reset_sclk", spiIf.sclk, 1'b0);
    checkValue("reset_mosi", spiIf.mosi, 1'b0);
    checkValue("reset_data_out", spiIf.data_out, 8'h00);
    checkValue("reset_vld", spiIf.data_out_vld, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] single write 0x20 <- 0xFF");
    wrData = '{8'hFF};
    slaveBytes.delete();
    applyStimulus("single_write", RW_WRITE, 7'h20, 1, 0, 0);

    $display("[TB] single read 0x20, slave 0xA5");
    wrData.delete();
    slaveBytes = '{8'hA5};
    applyStimulus("single_read", RW_READ, 7'h20, 1, 0, 0);

    $display("[TB] burst write 0x1E, 17 bytes");
    wrData.delete();
    for (int i = 1; i <= 17; i++) wrData.push_back(8'(i));
    slaveBytes.delete();
    applyStimulus("burst_write", RW_WRITE, 7'h1E, 17, 0, 0);

    $display("[TB] burst read 0x11, 9 bytes");
    wrData.delete();
    slaveBytes.delete();
    for (int i = 0; i < 9; i++) slaveBytes.push_back(8'($urandom_range(0, 255)));
    applyStimulus("burst_read", RW_READ, 7'h11, 9, 0, 0);

    $display("[TB] read aborted during bit 3 of first data byte");
    slaveBytes = '{8'hC3, 8'h99};
    applyStimulus("abort_read", RW_READ, 7'h33, 2, 1, BYTE_CLK + 3 * BIT_CLK + 30);

    $display("[TB] clean read after abort");
    slaveBytes = '{8'h3C};
    applyStimulus("post_abort_read", RW_READ, 7'h05, 1, 0, 0);

    $display("[TB] write to top address 0x7F");
    wrData = '{8'h81};
    slaveBytes.delete();
    applyStimulus("write_7f", RW_WRITE, 7'h7F, 1, 0, 0);

    $display("[TB] reset asserted mid burst read");
    wrData.delete();
    slaveBytes = '{8'h5E, 8'hE7, 8'h42, 8'h18, 8'hB1};
    applyStimulus("reset_burst", RW_READ, 7'h7F, 5, 2, 3 * BYTE_CLK + BYTE_CLK / 2);

    idleBusy = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (spiIf.cs_n !== 1'b1 || spiIf.sclk !== 1'b0 || spiIf.data_out_vld !== 1'b0)
        idleBusy = 1'b1;
    end
    checkValue("idle_after_reset", idleBusy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
